// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder/subtractor.
// It has one full-adder cell and handles one operand bit pair per clock, LSB
// first. The cell's carry-out is registered and fed back as the next bit's
// carry-in. Operands come in through a valid/ready handshake. The result is
// held on a valid/ready output until the consumer takes it.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_in_valid   operands present
//   o_in_ready   block can accept operands (IDLE)
//   i_op_a       operand A
//   i_op_b       operand B
//   i_op_cin     carry-in, add only (ignored when subtracting)
//   i_op_sub     1 = A - B, 0 = A + B + cin
//   o_out_valid  result available (DONE)
//   i_out_ready  consumer accepts result
//   o_sum        result, modulo 2^WIDTH
//   o_cout       carry-out of MSB (subtract: 1 = no borrow)
//   o_overflow   two's-complement overflow
//   o_zero       result == 0

// One-bit full-adder cell.
module serial_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_op_cin,
  input  logic             i_op_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_s;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  serial_adder_fa u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  assign w_accept   = (r_state == S_IDLE) && i_in_valid;
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  // Sum bits enter at the MSB. After WIDTH shifts the LSB has reached bit 0.
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)      w_state_next = S_DONE;
      S_DONE:  if (i_out_ready) w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  o_in_ready  = 1'b1;
      S_DONE:  o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_op_a;
      // Subtraction is A + ~B + 1. The +1 rides in on the initial carry.
      r_b     <= i_op_sub ? ~i_op_b : i_op_b;
      r_carry <= i_op_sub ? 1'b1 : i_op_cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_res   <= w_res_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // On the MSB step r_carry is the carry into the MSB. Overflow is
        // the carry into the MSB XOR the carry out of it.
        r_sum  <= w_res_next;
        r_cout <= w_cout;
        r_ovf  <= w_cout ^ r_carry;
        r_zero <= (w_res_next == '0);
        r_cnt  <= '0;
      end
    end
  end

  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_ovf;
  assign o_zero     = r_zero;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [W-1:0] i_op_a = '0;
  logic [W-1:0] i_op_b = '0;
  logic         i_op_cin = 1'b0;
  logic         i_op_sub = 1'b0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b1;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_overflow;
  logic         o_zero;

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .i_op_cin    (i_op_cin),
    .i_op_sub    (i_op_sub),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_sum       (o_sum),
    .o_cout      (o_cout),
    .o_overflow  (o_overflow),
    .o_zero      (o_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   last_acc = -1;
  bit   b2b = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: plain wide addition of the (possibly inverted) operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         m;
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   t;
    bb     = sub ? ~b : b;
    c      = sub ? 1'b1 : cin;
    t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    m.a    = a;
    m.b    = b;
    m.sub  = sub;
    m.sum  = t[W-1:0];
    m.cout = t[W];
    m.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    m.zero = (t[W-1:0] == '0);
    return m;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: push on accept, check latency / spacing, pop and compare on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (i_in_valid && o_in_ready) begin
        sb.push_back(model(i_op_a, i_op_b, i_op_cin, i_op_sub));
        if (b2b && last_acc >= 0) check_eq("accept_spacing", 32'(cyc + 1 - last_acc), W + 2);
        last_acc = cyc + 1;
        acc_edge = cyc + 1;
      end
      if (o_out_valid && !prev_valid) check_eq("latency", 32'(cyc - acc_edge), W);
      if (o_out_valid && i_out_ready) begin
        check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("sum", 32'(o_sum), 32'(e.sum));
          check_eq("cout", 32'(o_cout), 32'(e.cout));
          check_eq("overflow", 32'(o_overflow), 32'(e.ovf));
          check_eq("zero", 32'(o_zero), 32'(e.zero));
          $display("txn %s a=%02h b=%02h -> sum=%02h cout=%0d ovf=%0d zero=%0d",
                   e.sub ? "sub" : "add", e.a, e.b, o_sum, o_cout, o_overflow, o_zero);
        end
      end
      prev_valid = o_out_valid;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!o_in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!o_in_ready) check_eq("ready_timeout", 32'(o_in_ready), 1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("drain", 32'(sb.size()), 0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    wait_ready();
    i_op_a     = a;
    i_op_b     = b;
    i_op_cin   = cin;
    i_op_sub   = sub;
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   k;

    // Reset state
    #12;
    check_eq("rst_in_ready", 32'(o_in_ready), 1);
    check_eq("rst_out_valid", 32'(o_out_valid), 0);
    check_eq("rst_sum", 32'(o_sum), 0);
    check_eq("rst_cout", 32'(o_cout), 0);
    check_eq("rst_ovf", 32'(o_overflow), 0);
    check_eq("rst_zero", 32'(o_zero), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0); wait_drain();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0); wait_drain();
    do_op(8'h7F, 8'h00, 1'b1, 1'b0); wait_drain();
    do_op(8'h10, 8'h20, 1'b1, 1'b1); wait_drain();
    do_op(8'h80, 8'h01, 1'b1, 1'b1); wait_drain();

    // Backpressure in DONE with in_valid pulsing
    i_out_ready = 1'b0;
    do_op(8'h33, 8'h44, 1'b0, 1'b0);
    k = 0;
    while (!o_out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("bp_valid", 32'(o_out_valid), 1);
    e = model(8'h33, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      i_in_valid = (i % 2 == 0);
      i_op_a     = W'($urandom);
      i_op_b     = W'($urandom);
      i_op_sub   = 1'($urandom);
      @(posedge clk); #1;
      check_eq("bp_hold_valid", 32'(o_out_valid), 1);
      check_eq("bp_in_ready", 32'(o_in_ready), 0);
      check_eq("bp_sum", 32'(o_sum), 32'(e.sum));
      check_eq("bp_flags", {29'd0, o_cout, o_overflow, o_zero}, {29'd0, e.cout, e.ovf, e.zero});
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_idle", 32'(o_in_ready), 1);
    do_op(8'hC8, 8'h64, 1'b0, 1'b1); wait_drain();

    // Reset on the 4th RUN cycle
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    check_eq("abort_in_ready", 32'(o_in_ready), 1);
    check_eq("abort_out_valid", 32'(o_out_valid), 0);
    check_eq("abort_sum", 32'(o_sum), 0);
    check_eq("abort_flags", {29'd0, o_cout, o_overflow, o_zero}, 0);
    @(posedge clk); #1;
    check_eq("abort_hold_valid", 32'(o_out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h01, 8'h02, 1'b0, 1'b0); wait_drain();

    // Back-to-back random operations
    i_out_ready = 1'b1;
    b2b         = 1'b1;
    last_acc    = -1;
    i_in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_ready();
      i_op_a   = W'($urandom);
      i_op_b   = W'($urandom);
      i_op_cin = 1'($urandom);
      i_op_sub = 1'($urandom);
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    wait_drain();
    b2b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
